median3x3_pipe: RTL and testbench
=================================

MEDIAN3X3_PIPE -- requirements
Module: median3x3_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, pixel width in bits (legal 1..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  column offered this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept a column this cycle.
REQ-006 SHALL have port in_sol  input  1  offered column is the first column of a line.
REQ-007 SHALL have ports in_top, in_mid, in_bot  input  DATA_W each  the three rows of one image column.
REQ-008 SHALL have port mode  input  2  filter select: 0 median, 1 max, 2 min, 3 centre pass-through.
REQ-009 SHALL have port out_valid  output  1  out_pix holds a result.
REQ-010 SHALL have port out_ready  input  1  downstream accepts out_pix this cycle.
REQ-011 SHALL have port out_pix  output  DATA_W  filtered pixel.

Function
REQ-012 SHALL accept a column on any rising edge where in_valid and in_ready are both 1; otherwise the inputs are ignored.
REQ-013 SHALL drive in_ready = !out_valid || out_ready. The same signal is the global pipeline enable; when it is 0, all pipeline registers hold.
REQ-014 SHALL, on accept, sort the column into max/med/min, shift it into a 3-column window (oldest column dropped), and store the unsorted in_mid of that column.
REQ-015 SHALL keep a fill counter 0..3:
- on accept with in_sol=1: counter := 1 and the window restarts with this column;
- on accept with in_sol=0: counter := min(counter+1, 3).
REQ-016 SHALL create an output token only for an accept after which the counter equals 3; all other accepts create bubbles. A W-column line therefore yields W-2 results.
REQ-017 SHALL sample mode with the accepted column and carry it with that token; changing mode between tokens SHALL NOT affect tokens already in flight.
REQ-018 Stage 1 (window register) SHALL feed stage 2, which SHALL register:
- lo = max of the three column mins;
- md = med of the three column meds;
- hi = min of the three column maxes;
- the global max, the global min, and the centre pixel (unsorted mid row of the middle window column).
REQ-019 Stage 3 SHALL register out_pix as follows:
- mode 0: med(lo, md, hi);
- mode 1: global max;
- mode 2: global min;
- mode 3: centre pixel.
REQ-020 SHALL produce the exact order statistic for any input, including equal values. All comparisons are unsigned, DATA_W wide, with no width growth.
REQ-021 Latency: a token accepted on edge n SHALL set out_valid after edge n+2 when there is no stall. Sustained throughput SHALL be 1 result per cycle.
REQ-022 SHALL hold out_pix and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, when in_sol is accepted, leave tokens from the previous line already in flight to complete normally.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear:
- out_valid to 0 and out_pix to 0;
- the fill counter to 0;
- all pipeline valid bits to 0;
- all window and stage data registers to 0.
REQ-025 SHALL drive in_ready to 1 after reset release.
REQ-026 SHALL discard any in-flight tokens on reset; the first result after reset SHALL require three new accepted columns.

Verification
REQ-027 Basic median: DATA_W=8, mode=0, columns (10,20,30), (40,50,60), (70,80,90) accepted, in_sol=1 on the first -> exactly one result, out_pix=50, out_valid rising 2 cycles after the third accept.
REQ-028 Modes: the same three columns sent four times, once with each mode 1, 2, 3 and 0 -> out_pix 90, 10, 50, 50. Also send shuffled rows (90,10,50), (20,80,40), (60,30,70) with mode=0 -> out_pix 50; with mode=3 -> 80.
REQ-029 Ties and extremes: all nine pixels 7 -> 7 in every mode. Rows with values 0 and 255 mixed (five 255s, four 0s), mode=0 -> 255.
REQ-030 Line restart: two columns accepted, then in_sol=1 on the third -> no result until two further accepts. A 6-column line -> exactly 4 results.
REQ-031 Backpressure: 10-column stream with out_ready toggled pseudo-randomly -> no result lost or duplicated, out_pix stable while stalled, and results match the reference model in order.
REQ-032 Reset mid-stream: rst_n pulsed low while 2 tokens are in flight -> out_valid=0 immediately, no stale result afterwards, and the first new result appears only after three fresh accepts.

Source files
------------

// File: rtl/median3x3_pipe.sv
// median3x3_pipe: streaming 3x3 rank filter (median / max / min / centre).
// One image column (three rows) is accepted per cycle. A 3-column window is
// built from pre-sorted columns, reduced in stage 2, and the selected result
// is registered in stage 3. A single enable (in_ready) stalls every stage.
module median3x3_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sol,
    input  logic [DATA_W-1:0] in_top,
    input  logic [DATA_W-1:0] in_mid,
    input  logic [DATA_W-1:0] in_bot,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pix
);

    function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? b : a;
    endfunction

    // Median of three without width growth; exact for ties.
    function automatic logic [DATA_W-1:0] med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    // Stage 1 state: window of sorted columns, index 0 is the newest column.
    logic [1:0]        fill_q, fill_d;
    logic              s1_valid_q, s1_valid_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [DATA_W-1:0] win_max_q [3];
    logic [DATA_W-1:0] win_max_d [3];
    logic [DATA_W-1:0] win_med_q [3];
    logic [DATA_W-1:0] win_med_d [3];
    logic [DATA_W-1:0] win_min_q [3];
    logic [DATA_W-1:0] win_min_d [3];
    logic [DATA_W-1:0] win_mid_q [3];
    logic [DATA_W-1:0] win_mid_d [3];

    // Stage 2 state: partial order statistics of the window.
    logic              s2_valid_q, s2_valid_d;
    logic [1:0]        s2_mode_q, s2_mode_d;
    logic [DATA_W-1:0] s2_lo_q, s2_lo_d;
    logic [DATA_W-1:0] s2_md_q, s2_md_d;
    logic [DATA_W-1:0] s2_hi_q, s2_hi_d;
    logic [DATA_W-1:0] s2_gmax_q, s2_gmax_d;
    logic [DATA_W-1:0] s2_gmin_q, s2_gmin_d;
    logic [DATA_W-1:0] s2_ctr_q, s2_ctr_d;

    // Stage 3 state: the output register.
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_pix_q, out_pix_d;

    logic              accept;
    logic [DATA_W-1:0] col_max, col_med, col_min;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;

    // Sort the incoming column into max / med / min.
    always_comb begin
        col_max = max2(max2(in_top, in_mid), in_bot);
        col_min = min2(min2(in_top, in_mid), in_bot);
        col_med = med3(in_top, in_mid, in_bot);
    end

    // Stage 1 next state: shift window and track line fill on accept.
    always_comb begin
        fill_d     = fill_q;
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        for (int i = 0; i < 3; i++) begin
            win_max_d[i] = win_max_q[i];
            win_med_d[i] = win_med_q[i];
            win_min_d[i] = win_min_q[i];
            win_mid_d[i] = win_mid_q[i];
        end
        if (in_ready) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            // Older columns left in the window after a line start are harmless:
            // no token is produced until they have been shifted out.
            if (in_sol) begin
                fill_d = 2'd1;
            end else if (fill_q != 2'd3) begin
                fill_d = fill_q + 2'd1;
            end
            win_max_d[0] = col_max;
            win_med_d[0] = col_med;
            win_min_d[0] = col_min;
            win_mid_d[0] = in_mid;
            for (int i = 1; i < 3; i++) begin
                win_max_d[i] = win_max_q[i-1];
                win_med_d[i] = win_med_q[i-1];
                win_min_d[i] = win_min_q[i-1];
                win_mid_d[i] = win_mid_q[i-1];
            end
            s1_valid_d = (fill_d == 2'd3);
            s1_mode_d  = mode;
        end
    end

    // Stage 2 next state: reduce the three sorted columns.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_lo_d    = s2_lo_q;
        s2_md_d    = s2_md_q;
        s2_hi_d    = s2_hi_q;
        s2_gmax_d  = s2_gmax_q;
        s2_gmin_d  = s2_gmin_q;
        s2_ctr_d   = s2_ctr_q;
        if (in_ready) begin
            s2_valid_d = s1_valid_q;
            s2_mode_d  = s1_mode_q;
            s2_lo_d    = max2(max2(win_min_q[0], win_min_q[1]), win_min_q[2]);
            s2_md_d    = med3(win_med_q[0], win_med_q[1], win_med_q[2]);
            s2_hi_d    = min2(min2(win_max_q[0], win_max_q[1]), win_max_q[2]);
            s2_gmax_d  = max2(max2(win_max_q[0], win_max_q[1]), win_max_q[2]);
            s2_gmin_d  = min2(min2(win_min_q[0], win_min_q[1]), win_min_q[2]);
            s2_ctr_d   = win_mid_q[1];
        end
    end

    // Stage 3 next state: select the result for the token's mode.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pix_d   = out_pix_q;
        if (in_ready) begin
            out_valid_d = s2_valid_q;
            case (s2_mode_q)
                2'd0:    out_pix_d = med3(s2_lo_q, s2_md_q, s2_hi_q);
                2'd1:    out_pix_d = s2_gmax_q;
                2'd2:    out_pix_d = s2_gmin_q;
                default: out_pix_d = s2_ctr_q;
            endcase
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q     <= 2'd0;
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                win_max_q[i] <= '0;
                win_med_q[i] <= '0;
                win_min_q[i] <= '0;
                win_mid_q[i] <= '0;
            end
        end else begin
            fill_q     <= fill_d;
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            for (int i = 0; i < 3; i++) begin
                win_max_q[i] <= win_max_d[i];
                win_med_q[i] <= win_med_d[i];
                win_min_q[i] <= win_min_d[i];
                win_mid_q[i] <= win_mid_d[i];
            end
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_mode_q  <= 2'd0;
            s2_lo_q    <= '0;
            s2_md_q    <= '0;
            s2_hi_q    <= '0;
            s2_gmax_q  <= '0;
            s2_gmin_q  <= '0;
            s2_ctr_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_mode_q  <= s2_mode_d;
            s2_lo_q    <= s2_lo_d;
            s2_md_q    <= s2_md_d;
            s2_hi_q    <= s2_hi_d;
            s2_gmax_q  <= s2_gmax_d;
            s2_gmin_q  <= s2_gmin_d;
            s2_ctr_q   <= s2_ctr_d;
        end
    end

    // Stage 3 (output) registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pix_q   <= out_pix_d;
        end
    end

endmodule

// File: tb/tb_median3x3_pipe.sv
// tb_median3x3_pipe: directed and randomized checks of median3x3_pipe against
// a reference that sorts the nine window pixels and picks the requested rank.
module tb_median3x3_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sol;
    logic [W-1:0] in_top, in_mid, in_bot;
    logic [1:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_pix;

    median3x3_pipe #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sol    (in_sol),
        .in_top    (in_top),
        .in_mid    (in_mid),
        .in_bot    (in_bot),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int m;
        int b;
    } col_t;

    col_t win[$];      // columns of the current line, oldest first, at most 3
    int   exp_q[$];    // expected results in output order

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    logic last_valid = 1'b0;
    logic stall_prev = 1'b0;
    int   stall_pix  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: rank statistics of the nine window pixels.
    function automatic int model_result(input int md);
        int a[9];
        int tmp;
        for (int c = 0; c < 3; c++) begin
            a[3*c+0] = win[c].t;
            a[3*c+1] = win[c].m;
            a[3*c+2] = win[c].b;
        end
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    tmp = a[j]; a[j] = a[j+1]; a[j+1] = tmp;
                end
        case (md)
            0:       return a[4];
            1:       return a[8];
            2:       return a[0];
            default: return win[1].m;
        endcase
    endfunction

    // One clock cycle: check held output, drive inputs, score transfers.
    task automatic step(input logic v, input logic sol, input int t, input int m, input int b,
                        input int md, input logic ordy, output logic acc);
        col_t c;
        int   e;
        @(negedge clk);
        if (stall_prev) begin
            check("stall_valid", out_valid, 1);
            check("stall_pix", out_pix, stall_pix);
        end
        in_valid  = v;
        in_sol    = sol;
        in_top    = t[W-1:0];
        in_mid    = m[W-1:0];
        in_bot    = b[W-1:0];
        mode      = md[1:0];
        out_ready = ordy;
        #1;
        last_valid = out_valid;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                n_out++;
                $display("[TB] result %0d: pix=%0d exp=%0d", n_out, out_pix, e);
                check("pix", out_pix, e);
            end
        end
        stall_prev = out_valid && !out_ready;
        stall_pix  = out_pix;
        acc = v && in_ready;
        if (acc) begin
            c.t = t; c.m = m; c.b = b;
            if (sol) win.delete();
            win.push_back(c);
            if (win.size() > 3) win.delete(0);
            if (win.size() == 3) exp_q.push_back(model_result(md));
        end
    endtask

    task automatic send(input int t, input int m, input int b, input logic sol, input int md);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, sol, t, m, b, md, 1'b1, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, acc);
    endtask

    task automatic drain(input string tag);
        idle(6);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic send3(input int a0, input int a1, input int a2, input int b0, input int b1,
                         input int b2, input int c0, input int c1, input int c2, input int md);
        send(a0, a1, a2, 1'b1, md);
        send(b0, b1, b2, 1'b0, md);
        send(c0, c1, c2, 1'b0, md);
    endtask

    initial begin
        int   base;
        int   acc_cnt;
        int   guard;
        int   t, m, b, md;
        logic a;

        rst_n = 1'b0; in_valid = 1'b0; in_sol = 1'b0; in_top = '0; in_mid = '0; in_bot = '0;
        mode = 2'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pix", out_pix, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        // Basic median with latency check.
        base = n_out;
        send3(10, 20, 30, 40, 50, 60, 70, 80, 90, 0);
        idle(1); check("lat_edge1", last_valid, 0);
        idle(1); check("lat_edge2", last_valid, 0);
        idle(1); check("lat_edge3", last_valid, 1);
        drain("basic_drain");
        check("basic_count", n_out - base, 1);

        // Mode sweep and shuffled rows.
        for (int k = 0; k < 4; k++) begin
            int mlist[4] = '{1, 2, 3, 0};
            send3(10, 20, 30, 40, 50, 60, 70, 80, 90, mlist[k]);
        end
        send3(90, 10, 50, 20, 80, 40, 60, 30, 70, 0);
        send3(90, 10, 50, 20, 80, 40, 60, 30, 70, 3);
        drain("modes_drain");

        // Ties and extremes.
        for (int k = 0; k < 4; k++) send3(7, 7, 7, 7, 7, 7, 7, 7, 7, k);
        send3(255, 0, 255, 0, 255, 0, 255, 255, 0, 0);
        drain("ties_drain");

        // Line restart after two columns.
        base = n_out;
        send(1, 2, 3, 1'b1, 0);
        send(4, 5, 6, 1'b0, 0);
        send(9, 8, 7, 1'b1, 0);
        send(3, 3, 3, 1'b0, 0);
        idle(4);
        check("restart_none", n_out - base, 0);
        send(5, 1, 9, 1'b0, 0);
        drain("restart_drain");
        check("restart_count", n_out - base, 1);

        // Six-column line.
        base = n_out;
        for (int k = 0; k < 6; k++)
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), k == 0,
                 $urandom_range(0, 3));
        drain("line6_drain");
        check("line6_count", n_out - base, 4);

        // Backpressure with random gaps and random out_ready.
        base = n_out;
        acc_cnt = 0;
        guard = 0;
        t = $urandom_range(0, 255); m = $urandom_range(0, 255); b = $urandom_range(0, 255);
        md = $urandom_range(0, 3);
        while (acc_cnt < 10 && guard < 300) begin
            step($urandom_range(0, 3) != 0, acc_cnt == 0, t, m, b, md, 1'($urandom_range(0, 1)), a);
            if (a) begin
                acc_cnt++;
                t = $urandom_range(0, 255); m = $urandom_range(0, 255); b = $urandom_range(0, 255);
                md = $urandom_range(0, 3);
            end
            guard++;
        end
        check("bp_accepts", acc_cnt, 10);
        drain("bp_drain");
        check("bp_count", n_out - base, 8);

        // Reset while tokens are in flight.
        send3(11, 22, 33, 44, 55, 66, 77, 88, 99, 0);
        send(12, 13, 14, 1'b0, 1);
        send(15, 16, 17, 1'b0, 2);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_pix", out_pix, 0);
        exp_q.delete();
        win.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1);
        base = n_out;
        idle(4);
        check("no_stale", n_out - base, 0);
        send(3, 1, 2, 1'b0, 0);
        send(6, 5, 4, 1'b0, 0);
        idle(4);
        check("fresh_two", n_out - base, 0);
        send(9, 7, 8, 1'b0, 0);
        drain("fresh_drain");
        check("fresh_count", n_out - base, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
